// File: rtl/cache_victim_sel_pkg.sv
// Shared definitions for the cache replacement-way selector: FSM state
// encoding and default LFSR tap masks / seeds for the supported widths.
package cache_victim_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } sel_state_t;

    // Tap masks for a shift-left Fibonacci LFSR whose feedback enters bit 0.
    localparam logic [3:0] LFSR4_TAPS = 4'hC;
    localparam logic [3:0] LFSR4_SEED = 4'h1;
    localparam logic [7:0] LFSR8_TAPS = 8'h8E;
    localparam logic [7:0] LFSR8_SEED = 8'h01;

endpackage

// File: rtl/cache_victim_sel_lfsr.sv
// Free-running Fibonacci LFSR used as the random start-way source.
// Only the low OUT_W bits are exported; the full state stays internal.
module victim_lfsr #(
    parameter int                  WIDTH = 8,
    parameter logic [WIDTH-1:0]    TAPS  = 8'h8E,
    parameter logic [WIDTH-1:0]    SEED  = 8'h01,
    parameter int                  OUT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] value
);

    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] lfsr_next;

    always_comb begin
        lfsr_next = {lfsr_reg[WIDTH-2:0], ^(lfsr_reg & TAPS)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign value = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/cache_victim_sel.sv
// Replacement-way selector: prefers the lowest empty way, otherwise scans
// forward from an LFSR-chosen start way, one way per cycle, skipping locks.
module cache_victim_sel
    import cache_victim_sel_pkg::*;
#(
    parameter int                      WAYS       = 4,
    parameter int                      LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0]   LFSR_TAPS  = LFSR8_TAPS,
    parameter logic [LFSR_WIDTH-1:0]   SEED       = LFSR8_SEED,
    localparam int                     WAY_W      = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WAYS-1:0]  req_valid_mask,
    input  logic [WAYS-1:0]  req_lock_mask,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WAY_W-1:0] resp_way,
    output logic [WAYS-1:0]  resp_way_1h,
    output logic             resp_no_victim,
    output logic             resp_was_invalid
);

    sel_state_t       state_reg, state_next;
    logic [WAYS-1:0]  valid_reg, lock_reg;
    logic [WAY_W-1:0] ptr_reg, ptr_next;
    logic [WAY_W-1:0] tried_reg, tried_next;
    logic             accept;

    logic [WAY_W-1:0] way_reg, way_next;
    logic [WAYS-1:0]  way_1h_reg, way_1h_next;
    logic             no_victim_reg, no_victim_next;
    logic             was_invalid_reg, was_invalid_next;
    logic             resp_load;

    logic [WAY_W-1:0] start_way;
    logic [WAY_W-1:0] first_invalid;
    logic             any_invalid;

    victim_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED),
        .OUT_W (WAY_W)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (start_way)
    );

    // Descending loop so the lowest-index empty way wins.
    always_comb begin
        first_invalid = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                first_invalid = WAY_W'(i);
            end
        end
    end

    assign any_invalid = ~&valid_reg;

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        tried_next       = tried_reg;
        accept           = 1'b0;
        resp_load        = 1'b0;
        way_next         = way_reg;
        no_victim_next   = no_victim_reg;
        was_invalid_next = was_invalid_reg;
        req_ready        = 1'b0;

        case (state_reg)
            ST_SCAN: begin
                if (any_invalid) begin
                    resp_load        = 1'b1;
                    way_next         = first_invalid;
                    no_victim_next   = 1'b0;
                    was_invalid_next = 1'b1;
                    state_next       = ST_RESP;
                end else if (!lock_reg[ptr_reg]) begin
                    resp_load        = 1'b1;
                    way_next         = ptr_reg;
                    no_victim_next   = 1'b0;
                    was_invalid_next = 1'b0;
                    state_next       = ST_RESP;
                end else if (tried_reg == WAY_W'(WAYS - 1)) begin
                    resp_load        = 1'b1;
                    way_next         = '0;
                    no_victim_next   = 1'b1;
                    was_invalid_next = 1'b0;
                    state_next       = ST_RESP;
                end else begin
                    ptr_next   = ptr_reg + 1'b1;
                    tried_next = tried_reg + 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                // Covers IDLE and the unreachable encoding 3.
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    ptr_next   = start_way;
                    tried_next = '0;
                    state_next = ST_SCAN;
                end
            end
        endcase
    end

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_onehot
        assign way_1h_next[gi] = !no_victim_next && (way_next == WAY_W'(gi));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            valid_reg <= '0;
            lock_reg  <= '0;
            ptr_reg   <= '0;
            tried_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            tried_reg <= tried_next;
            if (accept) begin
                valid_reg <= req_valid_mask;
                lock_reg  <= req_lock_mask;
            end
        end
    end

    // Response fields load only when a decision is made, so they hold through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            way_reg         <= '0;
            way_1h_reg      <= '0;
            no_victim_reg   <= 1'b0;
            was_invalid_reg <= 1'b0;
        end else if (resp_load) begin
            way_reg         <= way_next;
            way_1h_reg      <= way_1h_next;
            no_victim_reg   <= no_victim_next;
            was_invalid_reg <= was_invalid_next;
        end
    end

    assign resp_valid       = (state_reg == ST_RESP);
    assign resp_way         = way_reg;
    assign resp_way_1h      = way_1h_reg;
    assign resp_no_victim   = no_victim_reg;
    assign resp_was_invalid = was_invalid_reg;

endmodule

// File: tb/tb_cache_victim_sel.sv
// Randomised self-checking bench for cache_victim_sel against a behavioural
// model of the selection rules and the LFSR sequence.
module tb_cache_victim_sel;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_valid_mask = 4'h0;
    logic [3:0] req_lock_mask = 4'h0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [1:0] resp_way;
    logic [3:0] resp_way_1h;
    logic       resp_no_victim;
    logic       resp_was_invalid;

    int checks = 0;
    int errors = 0;
    int txn_count = 0;

    logic [7:0] ref_lfsr;

    cache_victim_sel dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_valid_mask   (req_valid_mask),
        .req_lock_mask    (req_lock_mask),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_way         (resp_way),
        .resp_way_1h      (resp_way_1h),
        .resp_no_victim   (resp_no_victim),
        .resp_was_invalid (resp_was_invalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) ref_lfsr <= 8'h01;
        else       ref_lfsr <= {ref_lfsr[6:0], ^(ref_lfsr & 8'h8E)};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Selection rule stated directly: empty way first, else first unlocked way
    // walking forward from start, else no victim.
    task automatic ref_select(input logic [3:0] v, input logic [3:0] l, input int start,
                              output int way, output int nv, output int inv, output int lat);
        way = 0; nv = 0; inv = 0; lat = 4;
        for (int i = 3; i >= 0; i--) if (!v[i]) begin way = i; inv = 1; lat = 1; end
        if (inv == 0) begin
            nv = 1;
            for (int k = 3; k >= 0; k--) begin
                if (!l[(start + k) % 4]) begin way = (start + k) % 4; nv = 0; lat = k + 1; end
            end
            if (nv == 1) way = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        #1;
        check("rst_valid", resp_valid, 0);
        check("rst_way", resp_way, 0);
        check("rst_1h", resp_way_1h, 0);
        check("rst_nv", resp_no_victim, 0);
        check("rst_inv", resp_was_invalid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", req_ready, 1);
    endtask

    task automatic run_txn(input logic [3:0] v, input logic [3:0] l, input int hold);
        int start, way, nv, inv, lat, n;
        logic [3:0] exp_1h;
        start = int'(ref_lfsr[1:0]);
        ref_select(v, l, start, way, nv, inv, lat);
        exp_1h = (nv != 0) ? 4'h0 : (4'h1 << way);
        check("acc_ready", req_ready, 1);
        req_valid = 1'b1;
        req_valid_mask = v;
        req_lock_mask = l;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            check("scan_ready", req_ready, 0);
            req_valid_mask = 4'($urandom);
            req_lock_mask = 4'($urandom);
            tick();
            n++;
        end
        check("latency", n, lat);
        for (int h = 0; h <= hold; h++) begin
            check("resp_valid", resp_valid, 1);
            check("resp_ready_lo", req_ready, 0);
            check("resp_way", resp_way, way);
            check("resp_1h", resp_way_1h, exp_1h);
            check("resp_nv", resp_no_victim, nv);
            check("resp_inv", resp_was_invalid, inv);
            if (h < hold) begin
                req_valid = 1'($urandom);
                req_valid_mask = 4'($urandom);
                req_lock_mask = 4'($urandom);
                tick();
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("post_valid", resp_valid, 0);
        check("post_ready", req_ready, 1);
        txn_count++;
        $display("txn %0d valid=%b lock=%b start=%0d way=%0d no_victim=%0d was_invalid=%0d latency=%0d hold=%0d",
                 txn_count, v, l, start, way, nv, inv, n, hold);
    endtask

    initial begin
        logic [3:0] v, l;

        do_reset();
        run_txn(4'b1111, 4'b0000, 0);   // start 1 right after reset
        run_txn(4'b1011, 4'b1111, 1);   // empty way 2 beats all locks
        do_reset();
        run_txn(4'b1111, 4'b0110, 0);   // skips 1,2 -> way 3
        run_txn(4'b1111, 4'b1111, 2);   // no victim
        do_reset();
        run_txn(4'b1111, 4'b0001, 5);   // long hold with toggling masks
        run_txn(4'b1111, 4'b0000, 0);   // start follows current LFSR

        // Reset in the middle of a scan must drop the request.
        do_reset();
        req_valid = 1'b1;
        req_valid_mask = 4'b1111;
        req_lock_mask = 4'b1110;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_scan_ready", req_ready, 0);
        do_reset();
        run_txn(4'b1111, 4'b0000, 0);   // LFSR back at 01 -> way 1
        for (int i = 0; i < 4; i++) begin
            check("no_stale", resp_valid, 0);
            tick();
        end

        for (int t = 0; t < 60; t++) begin
            v = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
            l = 4'($urandom);
            if ($urandom_range(0, 4) == 0) l = 4'b1111;
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            run_txn(v, l, $urandom_range(0, 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_victim_sel.md
Name: cache_victim_sel

Overview:
- Replacement-way selector for the set-associative caches. Given the valid and lock bits of the indexed set, it picks one way to evict/refill.
- Empty ways are always preferred. Otherwise a random start way is taken from a free-running internal LFSR, and the block scans forward one way per cycle, skipping locked ways.
- Sits between the cache main FSM (requester) and the refill logic (consumer of the chosen way). Uses a valid/ready handshake on both sides.

Parameters:
- WAYS, 4, number of ways; power of two, 2..16.
- LFSR_WIDTH, 8, LFSR width; WAY_W <= LFSR_WIDTH <= 32.
- LFSR_TAPS, 8'h8E, feedback tap mask, LFSR_WIDTH bits; must be maximal-length.
- SEED, 8'h01, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  selection request
- req_ready  out  1  block can accept a request
- req_valid_mask  in  WAYS  valid bit per way of the indexed set
- req_lock_mask  in  WAYS  1 = way must not be evicted
- resp_valid  out  1  selection result available
- resp_ready  in  1  consumer takes the result
- resp_way  out  WAY_W  chosen way index (WAY_W = $clog2(WAYS))
- resp_way_1h  out  WAYS  one-hot of resp_way; all-zero when no_victim
- resp_no_victim  out  1  every way is valid and locked; no eviction is possible
- resp_was_invalid  out  1  chosen way was empty (no writeback check needed)

Behaviour:
- Reset (async assert, deassert synchronous to clk):
  - state = IDLE; LFSR = SEED.
  - Outputs: resp_valid = 0, resp_way = 0, resp_way_1h = 0, resp_no_victim = 0, resp_was_invalid = 0.
  - req_ready = 1 from the first cycle after reset.
- LFSR:
  - Advances every clock edge when not in reset, independent of state.
  - next = {lfsr[W-2:0], ^(lfsr & LFSR_TAPS)}.
  - Sequence for the defaults: 01, 02, 05, 0B, 16, ...
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid=1: capture both masks, capture start = lfsr[WAY_W-1:0] (the pre-edge value), set ptr = start and tried = 0, then go to SCAN.
- SCAN (req_ready = 0):
  - If any captured valid bit is 0: pick the lowest-index invalid way, set was_invalid = 1, go to RESP. The lock mask is ignored for invalid ways.
  - Else if lock[ptr] = 0: pick ptr, go to RESP.
  - Else if tried = WAYS-1: no_victim = 1, way = 0, go to RESP.
  - Else: ptr = (ptr + 1) mod WAYS (natural WAY_W-bit wrap), tried += 1, stay in SCAN.
- Latency from the accept edge to the first resp_valid cycle:
  - 1 cycle for an invalid-way hit or an unlocked start way.
  - k+1 cycles when k locked ways are skipped.
  - WAYS cycles for no_victim.
- RESP:
  - resp_valid = 1; all resp_* outputs are registered and held stable until an edge with resp_ready = 1, then go to IDLE.
  - req_ready stays 0 in RESP, so a new request is accepted no earlier than the cycle after the handshake.
- Mask inputs are sampled only at accept. Changes during SCAN/RESP have no effect.
- Reset asserted in any state aborts immediately and returns everything to its reset values. No response is issued for the aborted request.
- State encoding is a 2-bit register: IDLE = 0, SCAN = 1, RESP = 2. Value 3 is unreachable and decodes to IDLE.

Decomposition:
- Shared cache package holds the state enum (IDLE/SCAN/RESP) and the default LFSR_TAPS/SEED constants per width.
- One sub-module, victim_lfsr: async-reset, always-enabled Fibonacci LFSR, parameterised by width, taps and seed.
- Priority encode, one-hot conversion and scan logic stay in cache_victim_sel.

Test Plan (defaults: WAYS=4, LFSR_WIDTH=8, SEED=01, TAPS=8E):
- Reset, then req_valid=1 in the first cycle with valid=1111, lock=0000 -> start=1; resp_valid one cycle later; resp_way=1, resp_way_1h=0010, was_invalid=0.
- valid=1011, lock=1111, any LFSR value -> resp_way=2, was_invalid=1, latency 1.
- valid=1111, lock=0110, accepted when LFSR=01 -> scans 1, 2, 3; resp_way=3 with resp_valid in the 3rd cycle after accept.
- valid=1111, lock=1111 -> resp_no_victim=1, resp_way_1h=0000, resp_way=0, latency 4; req_ready=0 throughout.
- resp_ready held 0 for 5 cycles while both masks toggle -> all resp_* outputs stable and the LFSR keeps stepping (02, 05, 0B, ...). resp_ready=1 -> IDLE the next cycle, and the next accept uses the current LFSR value.
- reset pulsed mid-SCAN (lock=1110, start=1) -> resp_valid=0 immediately, LFSR=01, req_ready=1 after deassert, no stale response.
